// File: rtl/bot_mission_seq.sv
// bot_mission_seq: queued fault-repair mission sequencer driving the path-planning CPU
module bot_mission_seq #(
   parameter int UNIT_W = 2,
   parameter int EP_W = 5,
   parameter int QDEPTH = 4,
   parameter int PULSE_LEN = 3,
   parameter logic [(2**UNIT_W)*EP_W-1:0] EP_TABLE = 20'h9CD1D
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fault_valid,
   input  logic [UNIT_W-1:0]         fault_unit,
   output logic                      fault_ready,
   input  logic                      pick_valid,
   input  logic [UNIT_W-1:0]         pick_unit,
   input  logic                      nav_done,
   output logic                      cpu_en,
   output logic [EP_W-1:0]           ep,
   output logic                      i_fault,
   output logic                      mission_done,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic                      overflow,
   output logic [2:0]                state
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(PULSE_LEN + 1);
   localparam logic [PW:0] QMAX = (PW + 1)'(QDEPTH);
   typedef enum logic [2:0] {IDLE, GO_FAULT, PICK_WAIT, GO_SUPPLY, GO_DROP} st_t;
   st_t st;
   logic [UNIT_W-1:0] mem [QDEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt;
   logic [UNIT_W-1:0] head, idx;
   logic [EP_W-1:0] lut;
   logic nav_ok, pop, push, issue;
   assign head = mem[rd_ptr];
   assign fault_ready = q_count < QMAX;
   assign nav_ok = nav_done && !cpu_en;
   assign pop = st == GO_DROP && nav_ok;
   assign push = fault_valid && (fault_ready || pop);
   assign issue = (st == IDLE && q_count != '0) || (st == PICK_WAIT && pick_valid) || (st == GO_SUPPLY && nav_ok);
   assign idx = st == PICK_WAIT ? pick_unit : head;
   assign state = st;
   // Endpoint lookup for the unit named by the command being issued
   always_comb begin
      lut = '0;
      for (int k = 0; k < 2**UNIT_W; k++)
         lut = idx == UNIT_W'(k) ? EP_TABLE[k*EP_W +: EP_W] : lut;
   end
   // Fault storage; entries need no reset because the pointers define validity
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= fault_unit;
   // FIFO pointers, occupancy and sticky drop flag
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         q_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         q_count <= push && !pop ? q_count + 1'b1 : pop && !push ? q_count - 1'b1 : q_count;
         if (fault_valid && !push) overflow <= 1'b1;
      end
   // Mission phases, CPU command strobe and registered status outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= IDLE;
         cpu_en <= 1'b0;
         ep <= '0;
         cnt <= '0;
         i_fault <= 1'b0;
         mission_done <= 1'b0;
      end else begin
         mission_done <= pop;
         if (issue) begin
            ep <= lut;
            cpu_en <= 1'b1;
            cnt <= CW'(PULSE_LEN - 1);
         end else if (cpu_en) begin
            cpu_en <= cnt != '0;
            cnt <= cnt - 1'b1;
         end
         case (st)
            IDLE:      if (issue) begin i_fault <= 1'b1; st <= GO_FAULT; end
            GO_FAULT:  if (nav_ok) begin i_fault <= 1'b0; st <= PICK_WAIT; end
            PICK_WAIT: if (issue) st <= GO_SUPPLY;
            GO_SUPPLY: if (issue) begin i_fault <= 1'b1; st <= GO_DROP; end
            GO_DROP:   if (nav_ok) begin i_fault <= 1'b0; st <= IDLE; end
            default: begin
               st <= IDLE;
               cpu_en <= 1'b0;
               ep <= '0;
               cnt <= '0;
               i_fault <= 1'b0;
               mission_done <= 1'b0;
            end
         endcase
      end
endmodule

// File: doc/bot_mission_seq.md
Name: bot_mission_seq

Overview:
- Parametrised successor to the bot fault/pick/drop state sequencer.
- Queues incoming fault-unit reports in a FIFO of configurable depth.
- For each queued fault, runs a five-phase mission: go to the fault unit, wait for a pick request, go to the supply unit, return to the fault unit, retire.
- Each navigation leg is sent to the path-planning CPU as an endpoint from a parameter lookup table, with a cpu_en strobe of configurable length.

Parameters:
UNIT_W, 2, width of unit/supply identifiers; table holds 2**UNIT_W entries
EP_W, 5, width of endpoint node index
QDEPTH, 4, fault FIFO depth (power of two, >=2)
PULSE_LEN, 3, cycles cpu_en is held high per command (>=1)
EP_TABLE, 20'h9CD1D, packed endpoint LUT, entry k at bits [k*EP_W +: EP_W]; default unit0=29, unit1=8, unit2=19, unit3=19

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
fault_valid  in  1  fault report strobe, one report per high cycle
fault_unit  in  UNIT_W  faulty unit id, sampled with fault_valid
fault_ready  out  1  FIFO can accept a report this cycle
pick_valid  in  1  pick-block complete, supply unit available
pick_unit  in  UNIT_W  supply unit id, sampled with pick_valid
nav_done  in  1  single-cycle pulse from CPU, current leg reached
cpu_en  out  1  command strobe to path-planning CPU
ep  out  EP_W  endpoint node for current command
i_fault  out  1  high while bot is travelling to the fault unit (legs 1 and 3)
mission_done  out  1  one-cycle pulse when a fault is retired
q_count  out  clog2(QDEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a report was dropped
state  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, q_count=0, cpu_en=0, ep=0, i_fault=0, mission_done=0, overflow=0. Reset mid-mission aborts the mission and flushes the FIFO. The pulse counter clears.
- FIFO write: a push happens when fault_valid=1 and either (q_count<QDEPTH) or a pop occurs the same cycle.
- FIFO drop: fault_valid=1 when full with no pop drops the report and sets overflow, which stays set until reset.
- fault_ready = (q_count<QDEPTH).
- Pointers wrap modulo QDEPTH. Simultaneous push and pop leaves q_count unchanged.
- Command issue: on the issuing clock edge, ep <= EP_TABLE[idx] and cpu_en <= 1.
- cpu_en stays high exactly PULSE_LEN cycles, then drops. ep holds its value until the next issue.
- nav_done is ignored while cpu_en=1. pick_valid is ignored outside PICK_WAIT.
- FSM states:
  - IDLE(0): when q_count>0, issue with idx=head unit, set i_fault=1, go to GO_FAULT. A report pushed into an empty FIFO at edge N gives cpu_en=1 after edge N+1.
  - GO_FAULT(1): on nav_done, set i_fault=0 and go to PICK_WAIT.
  - PICK_WAIT(2): on pick_valid, issue with idx=pick_unit and go to GO_SUPPLY.
  - GO_SUPPLY(3): on nav_done, issue with idx=head unit, set i_fault=1, go to GO_DROP. The head entry stays in the FIFO until retired.
  - GO_DROP(4): on nav_done, pop the head, pulse mission_done for one cycle, set i_fault=0, go to IDLE.
- Back-to-back missions: IDLE re-issues on the cycle after retire if the FIFO is still non-empty, so there is one IDLE cycle between missions.
- Unused state encodings 5-7 return to IDLE with outputs at reset values, except that FIFO contents are kept.
- Fault reports arriving during any state are queued normally.

Test Plan:
- Single mission, defaults:
  - push unit 1 → ep=8, cpu_en high 3 cycles, i_fault=1.
  - nav_done → i_fault=0.
  - pick_valid with pick_unit=2 → ep=19, cpu_en 3 cycles.
  - nav_done → ep=8, i_fault=1.
  - nav_done → mission_done pulse, q_count 1→0, state IDLE.
- Queueing: push units 0,2,1 on consecutive cycles → q_count=3; missions run in order with GO_FAULT ep 29, 19, 8.
- Overflow: push 5 reports with no missions retiring and QDEPTH=4 → 4 accepted, fault_ready=0, 5th dropped, overflow=1 stays set until reset.
- Full plus simultaneous events: FIFO full, fault_valid coincident with the GO_DROP retire → report accepted, q_count stays 4, overflow stays 0.
- Ignore rules: nav_done during a cpu_en pulse → no state change; pick_valid during GO_FAULT → ignored, ep unchanged.
- Reset mid-mission: rst_n low during GO_SUPPLY with q_count=2 → all outputs immediately at reset values, FIFO empty; no command issued after release until a new push.
- Parametrised run: PULSE_LEN=1, QDEPTH=8, EP_W=6, custom EP_TABLE → cpu_en is 1 cycle wide and the correct 6-bit endpoints are emitted.
